// File: rtl/instr_loader_if.sv
// Source stream and instruction-memory write port of the instruction loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever feeds the program in and watches the memory writes come out.
interface instr_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: accepts a program as a valid/ready word stream, writes
// it into instruction memory from address 0 upward one cycle after each
// handshake, and releases the core once the last word (or the last memory
// location) has been written. A start request in IDLE or DONE (re)loads.
module instr_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_load,
    instr_loader_if.slave     bus,
    output logic              core_run,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] s_word;
    logic              handshake;
    logic              at_last_addr;
    logic              begin_load;
    logic              end_load;

    // s_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign handshake    = bus.s_valid && bus.s_ready;
    assign at_last_addr = (wr_ptr == {ADDR_W{1'b1}});
    // A start request during LOAD is ignored; only IDLE and DONE honour it.
    assign begin_load   = start_load && ((state == IDLE) || (state == DONE));
    // The load ends on the flagged last word or when memory is full.
    assign end_load     = handshake && (bus.s_last || at_last_addr);
    assign s_word       = bus.s_data;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        unique case (state)
            IDLE: if (start_load) next_state = LOAD;
            LOAD: if (end_load)   next_state = DONE;
            DONE: if (start_load) next_state = LOAD;
            default:              next_state = IDLE;
        endcase
    end

    // Registered status outputs, derived from the state being entered so
    // they line up with the state register itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.s_ready <= 1'b0;
            core_run    <= 1'b0;
        end else begin
            bus.s_ready <= (next_state == LOAD);
            core_run    <= (next_state == DONE);
        end
    end

    // Memory write port: one write, one cycle after each accepted word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
        end else begin
            bus.im_we <= handshake;
            if (handshake) begin
                bus.im_addr  <= wr_ptr;
                bus.im_wdata <= s_word;
            end
        end
    end

    // Write pointer, word count and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (begin_load) begin
            wr_ptr     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (handshake) begin
            // The pointer parks on the last location rather than wrapping;
            // the FSM leaves LOAD on that same transfer.
            if (!at_last_addr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            word_count <= word_count + (ADDR_W + 1)'(1);
            if (at_last_addr && !bus.s_last) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Two instances share clock and reset:
// dut_a uses the default 64-word memory, dut_b a 4-word memory for the
// overflow case. Expected writes are queued when a handshake is driven and
// popped by a per-instance monitor when im_we is seen.
module tb_instr_loader;

    localparam int DW   = 16;
    localparam int AW_A = 6;
    localparam int AW_B = 2;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start_a = 1'b0;
    logic            start_b = 1'b0;
    logic            core_run_a, core_run_b;
    logic            overflow_a, overflow_b;
    logic [AW_A:0]   wc_a;
    logic [AW_B:0]   wc_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ptr_a  = 0;
    int ptr_b  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;

    instr_loader_if #(.DATA_W(DW), .ADDR_W(AW_A)) a_if ();
    instr_loader_if #(.DATA_W(DW), .ADDR_W(AW_B)) b_if ();

    instr_loader #(.DATA_W(DW), .ADDR_W(AW_A)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .start_load (start_a),
        .bus        (a_if),
        .core_run   (core_run_a),
        .word_count (wc_a),
        .overflow   (overflow_a)
    );

    instr_loader #(.DATA_W(DW), .ADDR_W(AW_B)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .start_load (start_b),
        .bus        (b_if),
        .core_run   (core_run_b),
        .word_count (wc_b),
        .overflow   (overflow_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Scoreboard monitor for dut_a: checks address, data and exact cycle.
    always @(negedge clock) begin
        if (a_if.im_we === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL write_a_unexpected: got addr=%0d data=%h at cycle %0d, required no write",
                         a_if.im_addr, a_if.im_wdata, cyc);
            end else begin
                mon_a = q_a.pop_front();
                if (a_if.im_addr !== mon_a.addr[AW_A-1:0] || a_if.im_wdata !== mon_a.data || cyc != mon_a.due) begin
                    errors++;
                    $display("FAIL write_a: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                             a_if.im_addr, a_if.im_wdata, cyc, mon_a.addr, mon_a.data, mon_a.due);
                end
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            checks++;
            errors++;
            mon_a = q_a.pop_front();
            $display("FAIL write_a_missing: got im_we=%b at cycle %0d, required write addr=%0d data=%h",
                     a_if.im_we, cyc, mon_a.addr, mon_a.data);
        end
    end

    // Scoreboard monitor for dut_b.
    always @(negedge clock) begin
        if (b_if.im_we === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL write_b_unexpected: got addr=%0d data=%h at cycle %0d, required no write",
                         b_if.im_addr, b_if.im_wdata, cyc);
            end else begin
                mon_b = q_b.pop_front();
                if (b_if.im_addr !== mon_b.addr[AW_B-1:0] || b_if.im_wdata !== mon_b.data || cyc != mon_b.due) begin
                    errors++;
                    $display("FAIL write_b: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                             b_if.im_addr, b_if.im_wdata, cyc, mon_b.addr, mon_b.data, mon_b.due);
                end
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            checks++;
            errors++;
            mon_b = q_b.pop_front();
            $display("FAIL write_b_missing: got im_we=%b at cycle %0d, required write addr=%0d data=%h",
                     b_if.im_we, cyc, mon_b.addr, mon_b.data);
        end
    end

    task automatic drive(input bit sel, input bit valid, input logic [15:0] data, input bit last);
        if (sel) begin
            b_if.s_valid = valid;
            b_if.s_data  = data;
            b_if.s_last  = last;
        end else begin
            a_if.s_valid = valid;
            a_if.s_data  = data;
            a_if.s_last  = last;
        end
    endtask

    // Offer one word, wait (bounded) for s_ready, queue the expected write.
    task automatic send_word(input bit sel, input logic [15:0] data, input bit last, input bit also_start);
        int waited;
        bit rdy;
        @(negedge clock);
        drive(sel, 1'b1, data, last);
        if (also_start) begin
            if (sel) start_b = 1'b1;
            else     start_a = 1'b1;
        end
        waited = 0;
        rdy = sel ? b_if.s_ready : a_if.s_ready;
        while (!rdy && waited < 20) begin
            @(negedge clock);
            waited++;
            rdy = sel ? b_if.s_ready : a_if.s_ready;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready=0 after %0d cycles, required 1", waited);
        end else if (sel) begin
            q_b.push_back('{addr: 6'(ptr_b), data: data, due: cyc + 1});
            ptr_b++;
        end else begin
            q_a.push_back('{addr: 6'(ptr_a), data: data, due: cyc + 1});
            ptr_a++;
        end
        @(posedge clock);
        #1;
        drive(sel, 1'b0, 16'h0000, 1'b0);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clock);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (sel) ptr_b = 0;
        else     ptr_a = 0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({a_if.s_ready, a_if.im_we, core_run_a, overflow_a} !== 4'b0000 || wc_a !== '0 ||
            a_if.im_addr !== '0 || a_if.im_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b run=%b ovf=%b wc=%0d addr=%0d wdata=%h, required all 0",
                     a_if.s_ready, a_if.im_we, core_run_a, overflow_a, wc_a, a_if.im_addr, a_if.im_wdata);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (a_if.s_ready !== 1'b0 || core_run_a !== 1'b0 || b_if.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got ready_a=%b run_a=%b ready_b=%b, required 0 0 0",
                         a_if.s_ready, core_run_a, b_if.s_ready);
            end
        end
    endtask

    task automatic test_normal_load();
        pulse_start(1'b0);
        checks++;
        if (a_if.s_ready !== 1'b1 || core_run_a !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: got ready=%b run=%b, required ready=1 run=0", a_if.s_ready, core_run_a);
        end
        send_word(1'b0, 16'h1123, 1'b0, 1'b0);
        send_word(1'b0, 16'h2456, 1'b0, 1'b0);
        send_word(1'b0, 16'h3789, 1'b0, 1'b0);
        send_word(1'b0, 16'h4ABC, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (wc_a !== 7'd4 || core_run_a !== 1'b1 || overflow_a !== 1'b0 || a_if.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_done: got wc=%0d run=%b ovf=%b ready=%b, required wc=4 run=1 ovf=0 ready=0",
                     wc_a, core_run_a, overflow_a, a_if.s_ready);
        end
    endtask

    task automatic test_stalls();
        logic [15:0] words[4];
        words = '{16'h1123, 16'h2456, 16'h3789, 16'h4ABC};
        pulse_start(1'b0);
        checks++;
        if (core_run_a !== 1'b0 || wc_a !== 7'd0) begin
            errors++;
            $display("FAIL stall_entry: got run=%b wc=%0d, required run=0 wc=0", core_run_a, wc_a);
        end
        for (int i = 0; i < 4; i++) begin
            send_word(1'b0, words[i], (i == 3), 1'b0);
            if (i < 3) begin
                repeat (3) @(negedge clock);
                checks++;
                if (wc_a !== 7'(i + 1) || a_if.s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got wc=%0d ready=%b, required wc=%0d ready=1",
                             wc_a, a_if.s_ready, i + 1);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (wc_a !== 7'd4 || core_run_a !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got wc=%0d run=%b, required wc=4 run=1", wc_a, core_run_a);
        end
    endtask

    task automatic test_reload();
        pulse_start(1'b0);
        checks++;
        if (core_run_a !== 1'b0 || wc_a !== 7'd0 || a_if.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_entry: got run=%b wc=%0d ready=%b, required run=0 wc=0 ready=1",
                     core_run_a, wc_a, a_if.s_ready);
        end
        send_word(1'b0, 16'h7A01, 1'b0, 1'b0);
        checks++;
        if (core_run_a !== 1'b0) begin
            errors++;
            $display("FAIL reload_run_low: got run=%b, required 0", core_run_a);
        end
        send_word(1'b0, 16'h7B02, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (wc_a !== 7'd2 || core_run_a !== 1'b1 || overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL reload_done: got wc=%0d run=%b ovf=%b, required wc=2 run=1 ovf=0",
                     wc_a, core_run_a, overflow_a);
        end
    endtask

    task automatic test_overflow();
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_word(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        end
        @(negedge clock);
        drive(1'b1, 1'b1, 16'hC004, 1'b0);
        repeat (4) begin
            checks++;
            if (b_if.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL overflow_5th_refused: got ready=%b, required 0", b_if.s_ready);
            end
            @(negedge clock);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++;
        if (overflow_b !== 1'b1 || core_run_b !== 1'b1 || wc_b !== 3'd4) begin
            errors++;
            $display("FAIL overflow_flags: got ovf=%b run=%b wc=%0d, required ovf=1 run=1 wc=4",
                     overflow_b, core_run_b, wc_b);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start(1'b0);
        send_word(1'b0, 16'h5001, 1'b0, 1'b0);
        send_word(1'b0, 16'h5002, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b1, 16'h5003, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_if.s_ready, a_if.im_we, core_run_a, overflow_a} !== 4'b0000 || wc_a !== '0 ||
            a_if.im_addr !== '0 || a_if.im_wdata !== '0) begin
            errors++;
            $display("FAIL reset_async: got ready=%b we=%b run=%b ovf=%b wc=%0d addr=%0d wdata=%h, required all 0",
                     a_if.s_ready, a_if.im_we, core_run_a, overflow_a, wc_a, a_if.im_addr, a_if.im_wdata);
        end
        @(negedge clock);
        reset = 1'b0;
        ptr_a = 0;
        ptr_b = 0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (a_if.s_ready !== 1'b0 || core_run_a !== 1'b0 || wc_a !== '0) begin
                errors++;
                $display("FAIL reset_released_idle: got ready=%b run=%b wc=%0d, required 0 0 0",
                         a_if.s_ready, core_run_a, wc_a);
            end
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        @(negedge clock);
        drive(1'b0, 1'b1, 16'hDEAD, 1'b1);
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (a_if.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: got ready=%b, required 0", a_if.s_ready);
            end
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        pulse_start(1'b0);
        send_word(1'b0, 16'h9001, 1'b0, 1'b0);
        send_word(1'b0, 16'h9002, 1'b0, 1'b1);
        send_word(1'b0, 16'h9003, 1'b0, 1'b0);
        send_word(1'b0, 16'h9004, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (wc_a !== 7'd4 || core_run_a !== 1'b1 || overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL start_in_load_ignored: got wc=%0d run=%b ovf=%b, required wc=4 run=1 ovf=0",
                     wc_a, core_run_a, overflow_a);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        test_reset();
        test_normal_load();
        test_stalls();
        test_reload();
        test_overflow();
        test_reset_mid_load();
        test_ignored_inputs();
        repeat (3) @(negedge clock);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending writes, required 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
